// File: rtl/uart_apb_master_if.sv
// rtl/uart_apb_master_if.sv - command, response and APB signal bundle for uart_apb_master
interface uart_apb_master_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              cmd_valid_i;
    logic              cmd_ready_o;
    logic              cmd_write_i;
    logic [ADDR_W-1:0] cmd_addr_i;
    logic [DATA_W-1:0] cmd_wdata_i;
    logic              rsp_valid_o;
    logic [DATA_W-1:0] rsp_rdata_o;
    logic              rsp_err_o;
    logic              rsp_timeout_o;
    logic              psel_o;
    logic              penable_o;
    logic              pwrite_o;
    logic [ADDR_W-1:0] paddr_o;
    logic [DATA_W-1:0] pwdata_o;
    logic              pready_i;
    logic              pslverr_i;
    logic [DATA_W-1:0] prdata_i;

    modport master (
        input  cmd_valid_i, cmd_write_i, cmd_addr_i, cmd_wdata_i,
        input  pready_i, pslverr_i, prdata_i,
        output cmd_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o, rsp_timeout_o,
        output psel_o, penable_o, pwrite_o, paddr_o, pwdata_o
    );

    modport slave (
        output cmd_valid_i, cmd_write_i, cmd_addr_i, cmd_wdata_i,
        output pready_i, pslverr_i, prdata_i,
        input  cmd_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o, rsp_timeout_o,
        input  psel_o, penable_o, pwrite_o, paddr_o, pwdata_o
    );
endinterface

// File: rtl/uart_apb_master.sv
// rtl/uart_apb_master.sv - single-command APB initiator with wait-state timeout for the UART register bus
module uart_apb_master #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    output logic              busy_o,
    uart_apb_master_if.master bus
);
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS} state_t;

    state_t            r_state;
    state_t            w_next;
    logic [CNT_W-1:0]  r_wait_cnt;
    logic              r_pwrite;
    logic [ADDR_W-1:0] r_paddr;
    logic [DATA_W-1:0] r_pwdata;
    logic              r_rsp_valid;
    logic [DATA_W-1:0] r_rsp_rdata;
    logic              r_rsp_err;
    logic              r_rsp_timeout;
    logic              w_psel;
    logic              w_penable;
    logic              w_ready;
    logic              w_accept;
    logic              w_done;
    logic              w_timeout;

    assign w_accept  = w_ready & bus.cmd_valid_i;
    assign w_done    = (r_state == S_ACCESS) & bus.pready_i;
    // The counter holds the number of low-pready cycles already seen, so this is the TIMEOUT-th one.
    assign w_timeout = (TIMEOUT != 0) && (r_state == S_ACCESS) && !bus.pready_i
                       && (r_wait_cnt == TMO_LAST);

    always_comb begin
        w_next    = r_state;
        w_psel    = 1'b0;
        w_penable = 1'b0;
        w_ready   = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_ready = !rst_i;
                if (bus.cmd_valid_i && !rst_i) w_next = S_SETUP;
            end
            S_SETUP: begin
                w_psel = 1'b1;
                w_next = S_ACCESS;
            end
            S_ACCESS: begin
                w_psel    = 1'b1;
                w_penable = 1'b1;
                if (bus.pready_i || w_timeout) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state       <= S_IDLE;
            r_wait_cnt    <= '0;
            r_pwrite      <= 1'b0;
            r_paddr       <= '0;
            r_pwdata      <= '0;
            r_rsp_valid   <= 1'b0;
            r_rsp_rdata   <= '0;
            r_rsp_err     <= 1'b0;
            r_rsp_timeout <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_rsp_valid <= 1'b0;
            if (w_accept) begin
                r_pwrite <= bus.cmd_write_i;
                r_paddr  <= bus.cmd_addr_i;
                r_pwdata <= bus.cmd_wdata_i;
            end
            if (r_state == S_SETUP) begin
                r_wait_cnt <= '0;
            end else if (r_state == S_ACCESS && !bus.pready_i && r_wait_cnt != '1) begin
                r_wait_cnt <= r_wait_cnt + 1'b1;
            end
            // Completion takes priority over a timeout landing on the same cycle.
            if (w_done) begin
                r_rsp_valid   <= 1'b1;
                r_rsp_rdata   <= r_pwrite ? '0 : bus.prdata_i;
                r_rsp_err     <= bus.pslverr_i;
                r_rsp_timeout <= 1'b0;
            end else if (w_timeout) begin
                r_rsp_valid   <= 1'b1;
                r_rsp_rdata   <= '0;
                r_rsp_err     <= 1'b1;
                r_rsp_timeout <= 1'b1;
            end
        end
    end

    assign busy_o            = (r_state != S_IDLE);
    assign bus.cmd_ready_o   = w_ready;
    assign bus.psel_o        = w_psel;
    assign bus.penable_o     = w_penable;
    assign bus.pwrite_o      = r_pwrite;
    assign bus.paddr_o       = r_paddr;
    assign bus.pwdata_o      = r_pwdata;
    assign bus.rsp_valid_o   = r_rsp_valid;
    assign bus.rsp_rdata_o   = r_rsp_rdata;
    assign bus.rsp_err_o     = r_rsp_err;
    assign bus.rsp_timeout_o = r_rsp_timeout;
endmodule

// File: tb/tb_uart_apb_master.sv
// tb/tb_uart_apb_master.sv - directed bench for uart_apb_master with a register-file slave model
module tb_uart_apb_master;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic busy_a;
    logic busy_b;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_err = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_apb_master_if #(.ADDR_W(32), .DATA_W(32)) ifa ();
    uart_apb_master_if #(.ADDR_W(32), .DATA_W(32)) ifb ();

    uart_apb_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(16)) u_dut (
        .clk_i(clk), .rst_i(rst), .busy_o(busy_a), .bus(ifa)
    );
    uart_apb_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) u_dut_t4 (
        .clk_i(clk), .rst_i(rst), .busy_o(busy_b), .bus(ifb)
    );

    // Slave for ifa: 16-word register file, pready after cur_waits low ACCESS cycles.
    logic [31:0] mem [16];
    int          acc_cnt = 0;
    int          cur_waits = 0;
    logic        cur_err = 1'b0;

    assign ifa.pready_i  = ifa.psel_o && ifa.penable_o && (acc_cnt == cur_waits);
    assign ifa.pslverr_i = ifa.pready_i && cur_err;
    assign ifa.prdata_i  = ifa.pready_i ? mem[ifa.paddr_o[5:2]] : 32'hDEAD_BEEF;

    always @(posedge clk) begin
        if (ifa.psel_o && ifa.penable_o && !ifa.pready_i) acc_cnt <= acc_cnt + 1;
        else acc_cnt <= 0;
        if (ifa.pready_i && ifa.pwrite_o && !cur_err) mem[ifa.paddr_o[5:2]] <= ifa.pwdata_o;
    end

    typedef struct {
        string       name;
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          waits;
        logic        err;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic drive_a(input logic wr, input logic [31:0] addr, input logic [31:0] wdata);
        ifa.cmd_valid_i = 1'b1;
        ifa.cmd_write_i = wr;
        ifa.cmd_addr_i  = addr;
        ifa.cmd_wdata_i = wdata;
    endtask

    task automatic wait_rsp_a(output bit got);
        int n;
        got = 1'b0;
        n = 0;
        while (!got && n < 40) begin
            @(negedge clk);
            n++;
            got = ifa.rsp_valid_o;
        end
    endtask

    task automatic run_txn(input vec_t v);
        int   n;
        bit   got;
        bit   seq_ok;
        logic pe_exp;
        cur_waits = v.waits;
        cur_err   = v.err;
        @(negedge clk);
        drive_a(v.write, v.addr, v.wdata);
        chk({v.name, "_ready"}, 32'(ifa.cmd_ready_o), 32'd1);
        @(posedge clk);
        #1;
        ifa.cmd_valid_i = 1'b0;
        ifa.cmd_write_i = ~v.write;
        ifa.cmd_addr_i  = ~v.addr;
        ifa.cmd_wdata_i = ~v.wdata;
        n = 0;
        got = 1'b0;
        seq_ok = 1'b1;
        while (!got && n < 40) begin
            @(negedge clk);
            n++;
            if (ifa.rsp_valid_o) begin
                got = 1'b1;
                if (ifa.psel_o !== 1'b0 || busy_a !== 1'b0 || ifa.cmd_ready_o !== 1'b1) seq_ok = 1'b0;
            end else begin
                pe_exp = (n > 1);
                if (ifa.psel_o !== 1'b1 || ifa.penable_o !== pe_exp || ifa.paddr_o !== v.addr
                    || ifa.pwrite_o !== v.write || ifa.pwdata_o !== v.wdata
                    || ifa.cmd_ready_o !== 1'b0 || busy_a !== 1'b1) seq_ok = 1'b0;
            end
        end
        chk({v.name, "_seq"}, 32'(seq_ok), 32'd1);
        chk({v.name, "_lat"}, n, 3 + v.waits);
        chk({v.name, "_rdata"}, ifa.rsp_rdata_o, v.exp_rdata);
        chk({v.name, "_err"}, 32'(ifa.rsp_err_o), 32'(v.exp_err));
        chk({v.name, "_tmo"}, 32'(ifa.rsp_timeout_o), 32'd0);
        @(negedge clk);
        chk({v.name, "_pulse"}, {31'd0, ifa.rsp_valid_o}, 32'd0);
        chk({v.name, "_hold"}, ifa.rsp_rdata_o, v.exp_rdata);
        cur_err = 1'b0;
    endtask

    initial begin
        bit   got;
        bit   ok;
        int   k;
        int   n_acc;
        int   acc_cyc [4];
        vec_t extra;

        for (int i = 0; i < 16; i++) mem[i] = 32'h0;
        ifb.cmd_valid_i = 1'b0;
        ifb.cmd_write_i = 1'b0;
        ifb.cmd_addr_i  = 32'h0;
        ifb.cmd_wdata_i = 32'h0;
        ifb.pready_i    = 1'b0;
        ifb.pslverr_i   = 1'b0;
        ifb.prdata_i    = 32'h0;
        drive_a(1'b1, 32'h10, 32'h5555_0001);

        // Reset held 3 cycles with a command pending
        ok = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (ifa.psel_o !== 1'b0 || ifa.rsp_valid_o !== 1'b0 || ifa.cmd_ready_o !== 1'b0) ok = 1'b0;
        end
        chk("rst_quiet", 32'(ok), 32'd1);
        chk("rst_paddr", ifa.paddr_o, 32'h0);
        chk("rst_pwdata", ifa.pwdata_o, 32'h0);
        chk("rst_rdata", ifa.rsp_rdata_o, 32'h0);
        chk("rst_flags", {27'd0, ifa.pwrite_o, ifa.penable_o, ifa.rsp_err_o, ifa.rsp_timeout_o, busy_a}, 32'h0);
        rst = 1'b0;
        #1;
        chk("rst_release_ready", 32'(ifa.cmd_ready_o), 32'd1);
        @(posedge clk);
        #1;
        ifa.cmd_valid_i = 1'b0;
        @(negedge clk);
        chk("rst_release_setup", {30'd0, ifa.psel_o, ifa.penable_o}, 32'd2);
        wait_rsp_a(got);
        chk("rst_release_rsp", {ifa.rsp_err_o, 30'd0, got}, 32'd1);

        vecs[0] = '{"wr04",    1'b1, 32'h04, 32'hABCD_0002, 0,  1'b0, 32'h0,         1'b0};
        vecs[1] = '{"rd04",    1'b0, 32'h04, 32'h0000_0000, 0,  1'b0, 32'hABCD_0002, 1'b0};
        vecs[2] = '{"wr08_w5", 1'b1, 32'h08, 32'h1111_2222, 5,  1'b0, 32'h0,         1'b0};
        vecs[3] = '{"rd08_w5", 1'b0, 32'h08, 32'h0000_0000, 5,  1'b0, 32'h1111_2222, 1'b0};
        vecs[4] = '{"rd08_err",1'b0, 32'h08, 32'h0000_0000, 0,  1'b1, 32'h1111_2222, 1'b1};
        vecs[5] = '{"wr0c_err",1'b1, 32'h0C, 32'hCAFE_F00D, 2,  1'b1, 32'h0,         1'b1};
        vecs[6] = '{"rd0c",    1'b0, 32'h0C, 32'h0000_0000, 1,  1'b0, 32'h0,         1'b0};
        vecs[7] = '{"rd3c_w15",1'b0, 32'h3C, 32'h0000_0000, 15, 1'b0, 32'h0,         1'b0};
        vecs[8] = '{"wr3c",    1'b1, 32'h3C, 32'h0000_00FF, 1,  1'b0, 32'h0,         1'b0};
        vecs[9] = '{"rd3c",    1'b0, 32'h3C, 32'h0000_0000, 0,  1'b0, 32'h0000_00FF, 1'b0};
        for (int i = 0; i < 10; i++) run_txn(vecs[i]);

        // Back-to-back: cmd_valid held high across 4 writes
        cur_waits = 0;
        k = 0;
        ok = 1'b1;
        @(negedge clk);
        drive_a(1'b1, 32'h20, 32'hB0B0_0000);
        for (int t = 0; t < 40 && k < 4; t++) begin
            if (ifa.cmd_ready_o !== !busy_a) ok = 1'b0;
            got = ifa.cmd_ready_o;
            if (got) begin
                acc_cyc[k] = cyc;
                k++;
            end
            @(posedge clk);
            #1;
            if (got) begin
                if (k < 4) drive_a(1'b1, 32'h20 + 32'(4 * k), 32'hB0B0_0000 + 32'(k));
                else ifa.cmd_valid_i = 1'b0;
            end
            @(negedge clk);
        end
        chk("b2b_count", k, 4);
        chk("b2b_ready_vs_busy", 32'(ok), 32'd1);
        for (int i = 1; i < 4; i++) chk($sformatf("b2b_gap%0d", i), acc_cyc[i] - acc_cyc[i-1], 3);
        wait_rsp_a(got);
        extra = '{"rd2c_b2b", 1'b0, 32'h2C, 32'h0, 0, 1'b0, 32'hB0B0_0003, 1'b0};
        run_txn(extra);

        // Reset asserted during ACCESS
        cur_waits = 3;
        @(negedge clk);
        drive_a(1'b0, 32'h04, 32'h0);
        @(posedge clk);
        #1;
        ifa.cmd_valid_i = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("midrst_in_access", {30'd0, ifa.psel_o, ifa.penable_o}, 32'd3);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_bus_free", {30'd0, ifa.psel_o, ifa.penable_o}, 32'd0);
        rst = 1'b0;
        ok = (ifa.rsp_valid_o === 1'b0);
        repeat (6) begin
            @(negedge clk);
            if (ifa.rsp_valid_o !== 1'b0) ok = 1'b0;
        end
        chk("midrst_no_rsp", 32'(ok), 32'd1);
        chk("midrst_rdata", ifa.rsp_rdata_o, 32'h0);

        // Timeout on the TIMEOUT=4 instance, pready never rises
        @(negedge clk);
        ifb.cmd_valid_i = 1'b1;
        ifb.cmd_addr_i  = 32'h14;
        ifb.prdata_i    = 32'h1234_5678;
        @(posedge clk);
        #1;
        ifb.cmd_valid_i = 1'b0;
        n_acc = 0;
        got = 1'b0;
        for (int t = 0; t < 20 && !got; t++) begin
            @(negedge clk);
            if (ifb.rsp_valid_o) got = 1'b1;
            else if (ifb.penable_o) n_acc++;
        end
        chk("tmo_rsp", 32'(got), 32'd1);
        chk("tmo_access_cycles", n_acc, 4);
        chk("tmo_bus_dropped", {30'd0, ifb.psel_o, ifb.penable_o}, 32'd0);
        chk("tmo_flags", {30'd0, ifb.rsp_err_o, ifb.rsp_timeout_o}, 32'd3);
        chk("tmo_rdata", ifb.rsp_rdata_o, 32'h0);

        // pready on the 4th ACCESS cycle: completion wins over timeout
        @(negedge clk);
        ifb.cmd_valid_i = 1'b1;
        @(posedge clk);
        #1;
        ifb.cmd_valid_i = 1'b0;
        n_acc = 0;
        got = 1'b0;
        for (int t = 0; t < 20 && !got; t++) begin
            @(negedge clk);
            if (ifb.rsp_valid_o) got = 1'b1;
            else if (ifb.penable_o) begin
                n_acc++;
                if (n_acc == 4) begin
                    ifb.pready_i = 1'b1;
                    ifb.prdata_i = 32'h0000_5A5A;
                end
            end
        end
        ifb.pready_i = 1'b0;
        chk("edge_rsp", 32'(got), 32'd1);
        chk("edge_access_cycles", n_acc, 4);
        chk("edge_flags", {30'd0, ifb.rsp_err_o, ifb.rsp_timeout_o}, 32'd0);
        chk("edge_rdata", ifb.rsp_rdata_o, 32'h0000_5A5A);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
